// File: rtl/mult_par_seq.sv
// Sequential radix-2 shift-add multiplier with operand parity check and req/ack handshake.
// Optional macro MULT_RESULT_HOLD_EN adds result_ack and holds result_rdy until it is sampled.
module mult_par_seq #(
  parameter int WIDTH  = 16,
  parameter bit SIGNED = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   arg_a,
  input  logic               arg_a_parity,
  input  logic [WIDTH-1:0]   arg_b,
  input  logic               arg_b_parity,
  input  logic               req,
`ifdef MULT_RESULT_HOLD_EN
  input  logic               result_ack,
`endif
  output logic               ack,
  output logic [2*WIDTH-1:0] result,
  output logic               result_parity,
  output logic               arg_parity_error,
  output logic               result_rdy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, ACK, CALC, DONE} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0]   a_p0, b_p0;
  logic               perr_p0;
  logic [2*WIDTH-1:0] mcand_p1, acc_p1;
  logic [WIDTH-1:0]   mplier_p1;
  logic               neg_p1;
  logic [CW-1:0]      count_p1;
  logic [2*WIDTH-1:0] prod;
  logic               capture;
  logic               done_rel;
  logic               rdy_keep;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
    if (SIGNED && x[WIDTH-1]) return -x;
    return x;
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  function automatic logic parity(input logic [2*WIDTH-1:0] x);
    return ^x;
  endfunction

  assign capture = (state == IDLE) && req;
  assign prod    = apply_sign(acc_p1, neg_p1);

`ifdef MULT_RESULT_HOLD_EN
  assign done_rel = result_rdy & result_ack;
  assign rdy_keep = ~done_rel;
`else
  assign done_rel = 1'b1;
  assign rdy_keep = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = ACK;
      ACK:     state_nxt = perr_p0 ? DONE : CALC;
      CALC:    if (count_p1 == CW'(WIDTH-1)) state_nxt = DONE;
      DONE:    if (done_rel) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // p0: operand capture in IDLE
  always_ff @(posedge clk) begin
    if (capture) begin
      a_p0    <= arg_a;
      b_p0    <= arg_b;
      perr_p0 <= (^arg_a != arg_a_parity) | (^arg_b != arg_b_parity);
    end
  end

  // p1: magnitudes loaded in ACK, one partial product per CALC cycle
  always_ff @(posedge clk) begin
    if (state == ACK) begin
      mcand_p1  <= {{WIDTH{1'b0}}, magnitude(a_p0)};
      mplier_p1 <= magnitude(b_p0);
      neg_p1    <= SIGNED && (a_p0[WIDTH-1] ^ b_p0[WIDTH-1]);
      acc_p1    <= '0;
      count_p1  <= '0;
    end else if (state == CALC) begin
      if (mplier_p1[0]) acc_p1 <= acc_p1 + mcand_p1;
      mcand_p1  <= mcand_p1 << 1;
      mplier_p1 <= mplier_p1 >> 1;
      count_p1  <= count_p1 + 1'b1;
    end
  end

  // p2: registered outputs, loaded in DONE and cleared on the next capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      ack              <= 1'b0;
      result           <= '0;
      result_parity    <= 1'b0;
      arg_parity_error <= 1'b0;
      result_rdy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      ack        <= capture;
      result_rdy <= (state == DONE) && rdy_keep;
      if (capture) begin
        result           <= '0;
        result_parity    <= 1'b0;
        arg_parity_error <= 1'b0;
      end else if (state == DONE) begin
        result           <= perr_p0 ? '0 : prod;
        result_parity    <= perr_p0 ? 1'b0 : parity(prod);
        arg_parity_error <= perr_p0;
      end
    end
  end

endmodule

// File: doc/mult_par_seq.md
Name: mult_par_seq

Overview:
- Parametrised sequential signed/unsigned multiplier with argument parity checking and a req/ack handshake.
- Next-generation DUT for the multiplier testbench family: generalised in operand width and signedness mode.
- Adds registered result parity and a parity-error abort path.
- Sits behind the testbench BFM, which drives args+parity, raises req, waits ack, drops req, waits result_rdy.

Parameters:
WIDTH, 16, operand width in bits (>=2); result is 2*WIDTH bits
SIGNED, 1, 1 = two's-complement operands/result, 0 = unsigned

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
arg_a  input  WIDTH  operand A
arg_a_parity  input  1  expected parity of arg_a, equal to XOR of arg_a bits
arg_b  input  WIDTH  operand B
arg_b_parity  input  1  expected parity of arg_b
req  input  1  request; sampled only in IDLE
ack  output  1  one-cycle pulse: args captured
result  output  2*WIDTH  product, held until next capture
result_parity  output  1  XOR of result bits
arg_parity_error  output  1  set when captured args failed parity; held with result
result_rdy  output  1  result valid strobe

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (rst).
- While rst=1: state=IDLE; ack, result, result_parity, arg_parity_error, result_rdy all 0.
- Reset mid-operation aborts immediately; no result_rdy is produced for the aborted request.
- States: IDLE, ACK, CALC, DONE.
- IDLE: on a clk edge with req=1:
  - capture arg_a, arg_b, both parity bits;
  - perr = (^arg_a != arg_a_parity) | (^arg_b != arg_b_parity);
  - clear result, result_parity, arg_parity_error;
  - go to ACK.
- ACK: ack=1 for exactly this one cycle.
  - perr=1: next DONE.
  - perr=0: load multiplier datapath, count=0, next CALC.
- CALC: radix-2 shift-add, one partial product per cycle, exactly WIDTH cycles.
  - When count reaches WIDTH-1, next DONE.
- Arithmetic:
  - SIGNED=1: operate on magnitudes; negate the 2*WIDTH product if the operand signs differ.
  - Magnitude of -2^(WIDTH-1) fits unsigned in WIDTH bits; no overflow is possible.
  - SIGNED=0: plain unsigned product.
- DONE: result_rdy=1 for one cycle (see optional feature).
  - result, result_parity, arg_parity_error are valid, registered, and stable from this cycle until the next capture.
  - On parity error: result=0, result_parity=0, arg_parity_error=1.
  - Next state: IDLE.
- Latency, counting the capture edge as edge 0:
  - ack is high after edge 0.
  - result_rdy is high after edge WIDTH+2 on the normal path, after edge 2 on the error path.
- req while not IDLE is ignored; no queuing.
- req still high on return to IDLE starts a new transaction on the next edge (back-to-back allowed).
- Operand inputs may change freely after ack; only captured values are used.

Optional Feature:
MULT_RESULT_HOLD_EN
- Defined: adds input port result_ack (1 bit).
  - DONE holds result_rdy=1 until a clk edge samples result_ack=1, then goes to IDLE.
  - result_ack outside DONE is ignored.
- Undefined: no result_ack port; result_rdy is a single-cycle pulse as above.

Test Plan:
- WIDTH=16, SIGNED=1, a=3 (par 0), b=-4=0xFFFC (par 0), req held until ack -> ack one cycle after capture; result_rdy after edge 18; result=0xFFFFFFF4, result_parity=1, arg_parity_error=0.
- a=0x8000 (par 1), b=0x8000 (par 1) -> result=0x40000000, parity 1; then a=0x8000, b=0xFFFF (par 0) -> result=0x00008000, parity 1.
- SIGNED=0, a=0xFFFF, b=0xFFFF (par 0, 0) -> result=0xFFFE0001, result_parity=0.
- a=5 with arg_a_parity=1 (wrong), b=2 (par 1) -> ack after edge 0, result_rdy after edge 2, result=0, result_parity=0, arg_parity_error=1; the next valid request clears arg_parity_error.
- rst=1 asynchronously mid-CALC -> all outputs 0 immediately, no result_rdy; a fresh request after rst=0 completes normally.
- req held high continuously with changing operands -> consecutive transactions every WIDTH+3 cycles, each result matches its captured operands; with MULT_RESULT_HOLD_EN, result_rdy stays high until result_ack.
